// File: rtl/main_decoder.sv
// Registered main control decoder for the RV32I decode stage.
// Define MAINDEC_EXT_OPS_EN to also decode lui and jalr as legal opcodes.
module main_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [6:0] op,
  output logic [1:0] ResultSrc,
  output logic       MemWrite,
  output logic       Branch,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Jump,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUOp,
  output logic       Jalr,
  output logic       IllegalOp
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_BRANCH = 7'b1100011,
    OP_IALU   = 7'b0010011,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       jalr;
    logic       illegal_op;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // NOTE: every field gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    dec = '0;
    case (op)
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
      end
      OP_STORE: begin
        dec.imm_src   = 3'b001;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      OP_BRANCH: begin
        dec.imm_src = 3'b010;
        dec.branch  = 1'b1;
        dec.alu_op  = 2'b01;
      end
      OP_IALU: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b10;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = 3'b011;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
      end
`ifdef MAINDEC_EXT_OPS_EN
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = 3'b100;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b11;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
      end
`endif
      // Unsupported opcodes carry no side effects: only the flag is raised.
      default: dec.illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (en) ctrl_d = dec;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign RegWrite  = ctrl_q.reg_write;
  assign ImmSrc    = ctrl_q.imm_src;
  assign ALUSrc    = ctrl_q.alu_src;
  assign MemWrite  = ctrl_q.mem_write;
  assign ResultSrc = ctrl_q.result_src;
  assign Branch    = ctrl_q.branch;
  assign ALUOp     = ctrl_q.alu_op;
  assign Jump      = ctrl_q.jump;
  assign Jalr      = ctrl_q.jalr;
  assign IllegalOp = ctrl_q.illegal_op;

endmodule

// File: tb/tb_main_decoder.sv
// Self-checking bench for main_decoder: reset, opcode table, illegal ops,
// stall hold and the MAINDEC_EXT_OPS_EN opcodes (expectations follow the macro).
module tb_main_decoder;

  logic       clk;
  logic       reset;
  logic       en;
  logic [6:0] op;
  logic [1:0] ResultSrc;
  logic       MemWrite;
  logic       Branch;
  logic       ALUSrc;
  logic       RegWrite;
  logic       Jump;
  logic [2:0] ImmSrc;
  logic [1:0] ALUOp;
  logic       Jalr;
  logic       IllegalOp;

  main_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .op        (op),
    .ResultSrc (ResultSrc),
    .MemWrite  (MemWrite),
    .Branch    (Branch),
    .ALUSrc    (ALUSrc),
    .RegWrite  (RegWrite),
    .Jump      (Jump),
    .ImmSrc    (ImmSrc),
    .ALUOp     (ALUOp),
    .Jalr      (Jalr),
    .IllegalOp (IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch,
  // ALUOp, Jump, Jalr, IllegalOp.
  localparam logic [13:0] EXP_ZERO = 14'b0_000_0_0_00_0_00_0_0_0;
  localparam logic [13:0] EXP_LW   = 14'b1_000_1_0_01_0_00_0_0_0;
  localparam logic [13:0] EXP_SW   = 14'b0_001_1_1_00_0_00_0_0_0;
  localparam logic [13:0] EXP_R    = 14'b1_000_0_0_00_0_10_0_0_0;
  localparam logic [13:0] EXP_BEQ  = 14'b0_010_0_0_00_1_01_0_0_0;
  localparam logic [13:0] EXP_IALU = 14'b1_000_1_0_00_0_10_0_0_0;
  localparam logic [13:0] EXP_JAL  = 14'b1_011_0_0_10_0_00_1_0_0;
  localparam logic [13:0] EXP_ILL  = 14'b0_000_0_0_00_0_00_0_0_1;
`ifdef MAINDEC_EXT_OPS_EN
  localparam logic [13:0] EXP_LUI  = 14'b1_100_1_0_11_0_00_0_0_0;
  localparam logic [13:0] EXP_JALR = 14'b1_000_1_0_10_0_00_1_1_0;
`else
  localparam logic [13:0] EXP_LUI  = EXP_ILL;
  localparam logic [13:0] EXP_JALR = EXP_ILL;
`endif

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[12];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [13:0] outs();
    return {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch,
            ALUOp, Jump, Jalr, IllegalOp};
  endfunction

  task automatic check(input string name, input logic [13:0] act,
                       input logic [13:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Drive at the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input logic en_v, input logic [6:0] op_v);
    @(negedge clk);
    en = en_v;
    op = op_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"lw",        7'b0000011, EXP_LW};
    vecs[1]  = '{"sw",        7'b0100011, EXP_SW};
    vecs[2]  = '{"rtype",     7'b0110011, EXP_R};
    vecs[3]  = '{"beq",       7'b1100011, EXP_BEQ};
    vecs[4]  = '{"ialu",      7'b0010011, EXP_IALU};
    vecs[5]  = '{"jal",       7'b1101111, EXP_JAL};
    vecs[6]  = '{"ill_ones",  7'b1111111, EXP_ILL};
    vecs[7]  = '{"ill_zero",  7'b0000000, EXP_ILL};
    vecs[8]  = '{"ill_lo01",  7'b0000001, EXP_ILL};
    vecs[9]  = '{"ill_fence", 7'b0001111, EXP_ILL};
    vecs[10] = '{"lui",       7'b0110111, EXP_LUI};
    vecs[11] = '{"jalr",      7'b1100111, EXP_JALR};

    reset = 1'b0;
    en    = 1'b1;
    op    = 7'b0000011;
    @(posedge clk);
    #1;
    check("reset_state", outs(), EXP_ZERO);

    // First decode lands on the first enabled edge after release.
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 7'b0000011);
    check("post_reset_lw", outs(), EXP_LW);

    // Asynchronous clear mid-cycle, then held through an enabled edge.
    step(1'b1, 7'b0100011);
    check("pre_async_sw", outs(), EXP_SW);
    #2;
    reset = 1'b0;
    op    = 7'b0000011;
    #1;
    check("async_clear", outs(), EXP_ZERO);
    @(posedge clk);
    #1;
    check("reset_dominates_en", outs(), EXP_ZERO);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 7'b0000011);
    check("rerelease_lw", outs(), EXP_LW);

    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].op);
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    if (Jalr !== EXP_JALR[1]) $display("FAIL jalr_bit: got %b expected %b", Jalr, EXP_JALR[1]);
    n_checks++;
    if (Jalr === EXP_JALR[1]) n_pass++;

    // Stall: beq is held for three cycles while jal sits on op.
    step(1'b1, 7'b1100011);
    check("stall_beq", outs(), EXP_BEQ);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 7'b1101111);
      check($sformatf("stall_hold%0d", i), outs(), EXP_BEQ);
    end
    step(1'b1, 7'b1101111);
    check("stall_release_jal", outs(), EXP_JAL);

    // Back-to-back change with a stalled illegal op in between.
    step(1'b1, 7'b1111111);
    check("ill_then", outs(), EXP_ILL);
    step(1'b0, 7'b0110011);
    check("ill_hold", outs(), EXP_ILL);
    step(1'b1, 7'b0110011);
    check("r_after_ill", outs(), EXP_R);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/main_decoder.md
Name: main_decoder

Overview:
- Main control decoder for the single-issue RV32I core; sits in the decode stage beside the ALU decoder.
- Decodes the 7-bit opcode into datapath control: result mux, memory write, branch, ALU source, register write, jump, immediate format and ALU operation class.
- Outputs are registered, with a one-cycle latency, a stall enable and an illegal-opcode flag.

Parameters:
- None. Opcode encodings are fixed by RV32I.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  update enable. 0 holds all outputs (stall).
- op  input  7  instruction opcode, instr[6:0].
- ResultSrc  output  2  result mux select: 00=ALU, 01=memory, 10=PC+4, 11=immediate.
- MemWrite  output  1  data-memory write enable.
- Branch  output  1  conditional branch instruction.
- ALUSrc  output  1  ALU operand B: 0=rs2, 1=immediate.
- RegWrite  output  1  register-file write enable.
- Jump  output  1  unconditional jump.
- ImmSrc  output  3  immediate format: 000=I, 001=S, 010=B, 011=J, 100=U.
- ALUOp  output  2  to ALU decoder: 00=add, 01=subtract/compare, 10=use funct fields.
- Jalr  output  1  jump target is rs1+imm.
- IllegalOp  output  1  opcode not supported.

Behaviour:
- Combinational decode of op. The result is registered on the rising clk edge when en=1; when en=0 all outputs hold.
- reset low: every output clears to 0 immediately (asynchronous) and stays 0 while low. The first decode appears on the first rising edge with en=1 after reset goes high.
- Latency: exactly 1 cycle from op to outputs.
- Decode table (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump, Jalr):
  - lw 0000011: 1, 000, 1, 0, 01, 0, 00, 0, 0
  - sw 0100011: 0, 001, 1, 1, 00, 0, 00, 0, 0
  - R-type 0110011: 1, 000, 0, 0, 00, 0, 10, 0, 0
  - beq/branch 1100011: 0, 010, 0, 0, 00, 1, 01, 0, 0
  - I-ALU 0010011: 1, 000, 1, 0, 00, 0, 10, 0, 0
  - jal 1101111: 1, 011, 0, 0, 10, 0, 00, 1, 0
- Don't-care fields are driven as 0; no X is ever output.
- Any other opcode, including op[1:0]!=11: all controls 0 and IllegalOp=1.
  - Ensures no architectural side effects (no register write, no memory write).
- For every legal opcode, IllegalOp=0.
- en and reset interaction: reset dominates en.

Optional Feature:
- Macro: MAINDEC_EXT_OPS_EN.
- Defined: two additional opcodes decode as legal.
  - lui 0110111: RegWrite=1, ImmSrc=100, ALUSrc=1, ResultSrc=11, all others 0.
  - jalr 1100111: RegWrite=1, ImmSrc=000, ALUSrc=1, ResultSrc=10, ALUOp=00, Jump=1, Jalr=1.
- Not defined:
  - 0110111 and 1100111 are treated as illegal (IllegalOp=1).
  - Jalr is tied to 0.

Test Plan:
- Reset: reset=0 mid-cycle with op=0000011 -> all outputs 0 immediately. Release reset, en=1 -> next edge RegWrite=1, ALUSrc=1, ResultSrc=01, IllegalOp=0.
- Sweep legal opcodes (lw, sw, R, beq, I-ALU, jal), one per cycle, en=1 -> each output row matches the table one cycle later. Example: sw gives MemWrite=1, ImmSrc=001, RegWrite=0.
- Illegal op: op=1111111 and op=0000000 -> all controls 0, IllegalOp=1.
- Stall: decode beq, then en=0 and op=1101111 for 3 cycles -> outputs hold Branch=1, ALUOp=01. Raise en -> Jump=1, ResultSrc=10.
- Feature: op=0110111 -> with MAINDEC_EXT_OPS_EN, ImmSrc=100, ResultSrc=11, RegWrite=1. Without the macro, IllegalOp=1.
- Feature: op=1100111 -> with MAINDEC_EXT_OPS_EN, Jump=1, Jalr=1, ResultSrc=10. Without the macro, IllegalOp=1 and Jalr=0.
